// File: rtl/spi_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_seq_ctrl_if
// Bus bundle between the SPI frame sequencer and its three neighbours:
// the command RAM, the SPI shift engine and the result FIFO.
//
// Signals (direction seen from the sequencer, modport master):
//   cmd_addr   out  CNT_W    command RAM read address
//   cmd_data   in   FRAME_W  command RAM data, one cycle after cmd_addr
//   spi_start  out  1        one-cycle launch pulse to the SPI engine
//   spi_tx     out  FRAME_W  MOSI frame, stable from spi_start to spi_done
//   spi_done   in   1        one-cycle frame-complete pulse
//   spi_rx     in   FRAME_W  MISO frame, valid with spi_done
//   fifo_din   out  32       {zero pad, frame index, spi_rx}
//   fifo_wr_en out  1        one-cycle FIFO write strobe
//   fifo_full  in   1        FIFO backpressure
// The slave modport is the mirror image, for the RAM/SPI/FIFO side.
// ---------------------------------------------------------------------------
interface spi_seq_ctrl_if #(
   parameter int FRAME_W = 16,
   parameter int CNT_W   = 6
);
   logic [CNT_W-1:0]   cmd_addr;
   logic [FRAME_W-1:0] cmd_data;
   logic               spi_start;
   logic [FRAME_W-1:0] spi_tx;
   logic               spi_done;
   logic [FRAME_W-1:0] spi_rx;
   logic [31:0]        fifo_din;
   logic               fifo_wr_en;
   logic               fifo_full;

   modport master (
      output cmd_addr, spi_start, spi_tx, fifo_din, fifo_wr_en,
      input  cmd_data, spi_done, spi_rx, fifo_full
   );

   modport slave (
      input  cmd_addr, spi_start, spi_tx, fifo_din, fifo_wr_en,
      output cmd_data, spi_done, spi_rx, fifo_full
   );
endinterface

// File: rtl/spi_seq_ctrl.sv
// ---------------------------------------------------------------------------
// spi_seq_ctrl
// Runs a sequence of num_frames SPI transfers: for each frame it reads a
// command word from the command RAM, launches the SPI engine with it, waits
// for the reply and pushes {index, reply} into the result FIFO, then idles
// GAP_CYCLES cycles (chip-select high time) before the next frame.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start_trig       one-cycle start pulse (ignored while busy or aborting)
//   abort            level, returns to IDLE at the next edge
//   num_frames       frames per sequence, sampled on an accepted start
//   bus              spi_seq_ctrl_if.master (command RAM, SPI engine, FIFO)
//   busy             high in every state except IDLE
//   done             sticky sequence-complete flag
//   frame_cnt        frames stored in the current sequence
//   timeout_err      sticky SPI watchdog error
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to enable the spi_done
// watchdog (TIMEOUT_CYCLES cycles in XFER). Without it XFER waits forever
// and timeout_err is constant 0.
// ---------------------------------------------------------------------------
module spi_seq_ctrl #(
   parameter int FRAME_W        = 16,
   parameter int CNT_W          = 6,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_trig,
   input  logic              abort,
   input  logic [CNT_W-1:0]  num_frames,
   spi_seq_ctrl_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              timeout_err
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      LAUNCH,
      XFER,
      STORE,
      GAP
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   nf_lat;
   logic [GAP_W-1:0]   gap_cnt;
   logic               spi_start_q;
   logic [FRAME_W-1:0] spi_tx_q;
   logic [31:0]        fifo_din_q;
   logic               fifo_wr_en_q;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wdog;
   logic            timeout_q;
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Right-aligned FIFO word: reply in the low FRAME_W bits, frame index
   // directly above it, zeros on top.
   function automatic logic [31:0] pack_din(input logic [CNT_W-1:0]   idx,
                                            input logic [FRAME_W-1:0] rx);
      logic [31:0] w;
      w = 32'(rx);
      w = w | (32'(idx) << FRAME_W);
      return w;
   endfunction

   // The address tracks frame_cnt in every state, so it is already valid
   // during FETCH and the synchronous RAM output is ready in WAIT_DATA.
   assign bus.cmd_addr   = frame_cnt;
   assign bus.spi_start  = spi_start_q;
   assign bus.spi_tx     = spi_tx_q;
   assign bus.fifo_din   = fifo_din_q;
   assign bus.fifo_wr_en = fifo_wr_en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         nf_lat       <= '0;
         gap_cnt      <= '0;
         frame_cnt    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         spi_start_q  <= 1'b0;
         spi_tx_q     <= '0;
         fifo_din_q   <= '0;
         fifo_wr_en_q <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
         wdog         <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle unless re-armed below.
         spi_start_q  <= 1'b0;
         fifo_wr_en_q <= 1'b0;

         if (abort) begin
            // Abort beats everything, including a start in IDLE; counters
            // and flags are left as they are.
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_trig) begin
                     nf_lat    <= num_frames;
                     frame_cnt <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
                     timeout_q <= 1'b0;
`endif
                     // An empty sequence completes immediately.
                     done <= (num_frames == '0);
                     if (num_frames != '0) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                     end
                  end
               end

               FETCH: state <= WAIT_DATA;

               WAIT_DATA: begin
                  spi_tx_q    <= bus.cmd_data;
                  spi_start_q <= 1'b1;
                  state       <= LAUNCH;
               end

               LAUNCH: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                  wdog <= '0;
`endif
                  state <= XFER;
               end

               XFER: begin
                  if (bus.spi_done) begin
                     fifo_din_q <= pack_din(frame_cnt, bus.spi_rx);
                     state      <= STORE;
                  end
`ifdef SPI_SEQ_TIMEOUT_EN
                  else if (wdog == WD_LAST) begin
                     timeout_q <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     wdog <= wdog + WD_W'(1);
                  end
`endif
               end

               STORE: begin
                  // Hold the captured word until the FIFO has room.
                  if (!bus.fifo_full) begin
                     fifo_wr_en_q <= 1'b1;
                     frame_cnt    <= frame_cnt + CNT_ONE;
                     if ((frame_cnt + CNT_ONE) == nf_lat) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                     end
                  end
               end

               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     state <= FETCH;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end

               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_seq_ctrl
// Directed bench for spi_seq_ctrl with a command RAM model (addr i holds
// 16'hA000+i), an SPI engine model that answers ~tx SPI_LAT cycles after
// launch, and a scoreboard queue of expected FIFO words.
// ---------------------------------------------------------------------------
module tb_spi_seq_ctrl;
   localparam int FRAME_W        = 16;
   localparam int CNT_W          = 6;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int SPI_LAT        = 40;
   // Launch cycle + SPI_LAT counting cycles, done seen on the cycle after.
   localparam int XFER_CYC       = SPI_LAT + 1;
   localparam int FRAME_PERIOD   = 4 + GAP_CYCLES + XFER_CYC;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start_trig = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] num_frames = '0;
   logic             busy, done, timeout_err;
   logic [CNT_W-1:0] frame_cnt;

   spi_seq_ctrl_if #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) bus ();

   spi_seq_ctrl #(
      .FRAME_W(FRAME_W), .CNT_W(CNT_W),
      .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start_trig(start_trig), .abort(abort),
      .num_frames(num_frames), .bus(bus), .busy(busy), .done(done),
      .frame_cnt(frame_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Command RAM: synchronous read, one cycle latency.
   always @(posedge clk) bus.cmd_data <= 16'hA000 + 16'(bus.cmd_addr);

   // SPI engine: replies with the inverted command after SPI_LAT cycles.
   logic               spi_withhold = 1'b0;
   logic               m_busy = 1'b0;
   int                 m_cnt = 0;
   logic [FRAME_W-1:0] m_tx = '0;
   initial begin
      bus.spi_done = 1'b0;
      bus.spi_rx   = '0;
   end
   always @(posedge clk) begin
      bus.spi_done <= 1'b0;
      if (bus.spi_start) begin
         m_busy <= 1'b1;
         m_cnt  <= 0;
         m_tx   <= bus.spi_tx;
      end else if (m_busy) begin
         if (m_cnt == SPI_LAT - 1) begin
            m_busy <= 1'b0;
            if (!spi_withhold) begin
               bus.spi_done <= 1'b1;
               bus.spi_rx   <= ~m_tx;
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          starts_seq = 0;
   int          starts_tot = 0;
   int          writes_seq = 0;
   int          start_cyc[2];
   int          full_idx = -1;
   int          full_delay = 0;
   int          full_hold = 0;
   logic        full_d = 1'b0;
   logic [31:0] exp_q[$];

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not finish in time");
      $fatal(1, "global watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_din(input int i);
      logic [15:0] rx;
      logic [31:0] w;
      rx = ~(16'hA000 + 16'(i));
      w  = {10'd0, 6'(i), rx};
      return w;
   endfunction

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(exp_din(i));
   endtask

   // One clock: sample DUT 1 time unit after the edge, run the scoreboard,
   // then update the fifo_full schedule.
   task automatic step();
      logic [31:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.spi_start) begin
         chk("tx_frame", 32'(bus.spi_tx), 32'(16'hA000 + 16'(starts_seq)));
         chk("start_wr_exclusive", 32'(bus.fifo_wr_en), 32'd0);
         if (starts_seq < 2) start_cyc[starts_seq] = cyc;
         if (starts_seq == full_idx) full_delay = 35;
         starts_seq++;
         starts_tot++;
      end
      if (bus.fifo_wr_en) begin
         writes_seq++;
         chk("no_write_while_full", 32'(full_d), 32'd0);
         chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fifo_din", bus.fifo_din, e);
         end
      end
      if (full_delay > 0) begin
         full_delay--;
         if (full_delay == 0) begin
            bus.fifo_full = 1'b1;
            full_hold = 20;
         end
      end else if (full_hold > 0) begin
         full_hold--;
         if (full_hold == 0) bus.fifo_full = 1'b0;
      end
      full_d = bus.fifo_full;
   endtask

   task automatic pulse_start(input int nf);
      num_frames = CNT_W'(nf);
      start_trig = 1'b1;
      starts_seq = 0;
      writes_seq = 0;
      step();
      start_trig = 1'b0;
   endtask

   task automatic run_to_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      chk("seq_in_budget", 32'(busy), 32'd0);
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n = 0;
      while (starts_seq < target && n < budget) begin
         step();
         n++;
      end
      chk("start_reached", 32'(starts_seq >= target), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      chk({tag, "_cmd_addr"}, 32'(bus.cmd_addr), 32'd0);
      chk({tag, "_spi_tx"}, 32'(bus.spi_tx), 32'd0);
      chk({tag, "_fifo_din"}, bus.fifo_din, 32'd0);
      chk({tag, "_spi_start"}, 32'(bus.spi_start), 32'd0);
      chk({tag, "_fifo_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      int tot;
      int busy_seen;
      bus.fifo_full = 1'b0;

      // Reset state.
      reset_n = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) step();

      // Abort wins over a simultaneous start in IDLE.
      num_frames = CNT_W'(5);
      abort = 1'b1;
      start_trig = 1'b1;
      step();
      abort = 1'b0;
      start_trig = 1'b0;
      repeat (3) step();
      chk("abort_vs_start_busy", 32'(busy), 32'd0);
      chk("abort_vs_start_nolaunch", 32'(starts_tot), 32'd0);

      // Five-frame sequence; a start while busy with num_frames=3 is ignored.
      push_exp(5);
      pulse_start(5);
      chk("seq5_busy", 32'(busy), 32'd1);
      wait_starts(1, 50);
      num_frames = CNT_W'(3);
      start_trig = 1'b1;
      step();
      start_trig = 1'b0;
      run_to_idle(600);
      chk("seq5_done", 32'(done), 32'd1);
      chk("seq5_frame_cnt", 32'(frame_cnt), 32'd5);
      chk("seq5_starts", 32'(starts_seq), 32'd5);
      chk("seq5_writes", 32'(writes_seq), 32'd5);
      chk("seq5_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("frame_period", 32'(start_cyc[1] - start_cyc[0]), 32'(FRAME_PERIOD));
      repeat (5) step();

      // Abort during the XFER of frame 2; the late spi_done must be ignored.
      push_exp(2);
      pulse_start(5);
      wait_starts(3, 300);
      repeat (10) step();
      abort = 1'b1;
      start_trig = 1'b1;
      step();
      abort = 1'b0;
      start_trig = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("abort_done", 32'(done), 32'd0);
      tot = starts_tot;
      repeat (60) step();
      chk("abort_no_launch", 32'(starts_tot), 32'(tot));
      chk("abort_writes", 32'(writes_seq), 32'd2);
      chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("abort_frame_cnt_held", 32'(frame_cnt), 32'd2);

      // Zero-frame sequence: done one cycle later, never busy, no launch.
      chk("zero_done_before", 32'(done), 32'd0);
      tot = starts_tot;
      busy_seen = 0;
      pulse_start(0);
      chk("zero_done", 32'(done), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (busy) busy_seen++;
         step();
      end
      chk("zero_busy", 32'(busy_seen), 32'd0);
      chk("zero_no_launch", 32'(starts_tot), 32'(tot));

      // Clean restart after the abort.
      push_exp(5);
      pulse_start(5);
      run_to_idle(600);
      chk("restart_done", 32'(done), 32'd1);
      chk("restart_frame_cnt", 32'(frame_cnt), 32'd5);
      chk("restart_starts", 32'(starts_seq), 32'd5);
      chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (5) step();

      // 31 frames with fifo_full held for 20 cycles across frame 3's STORE.
      push_exp(31);
      full_idx = 3;
      pulse_start(31);
      run_to_idle(2500);
      full_idx = -1;
      chk("full31_done", 32'(done), 32'd1);
      chk("full31_frame_cnt", 32'(frame_cnt), 32'd31);
      chk("full31_writes", 32'(writes_seq), 32'd31);
      chk("full31_sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (5) step();

`ifdef SPI_SEQ_TIMEOUT_EN
      // Watchdog: spi_done withheld for one frame.
      spi_withhold = 1'b1;
      pulse_start(1);
      wait_starts(1, 50);
      tot = cyc;
      run_to_idle(200);
      chk("timeout_xfer_cycles", 32'(cyc - tot), 32'(TIMEOUT_CYCLES + 1));
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      chk("timeout_done", 32'(done), 32'd0);
      chk("timeout_no_write", 32'(writes_seq), 32'd0);
      spi_withhold = 1'b0;
      repeat (5) step();
      pulse_start(0);
      chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
      repeat (5) step();
`endif

      // Reset in the middle of frame 1: outputs clear at once, no resume.
      push_exp(1);
      pulse_start(5);
      wait_starts(2, 200);
      repeat (5) step();
      reset_n = 1'b0;
      #2;
      chk_all_zero("midreset");
      step();
      reset_n = 1'b1;
      tot = starts_tot;
      repeat (80) step();
      chk("midreset_no_launch", 32'(starts_tot), 32'(tot));
      chk("midreset_idle", 32'(busy), 32'd0);
      chk("midreset_sb_empty", 32'(exp_q.size()), 32'd0);

`ifndef SPI_SEQ_TIMEOUT_EN
      chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
